// File: rtl/fc_port_state_ctrl_pkg.sv
// Shared Fibre Channel types for the port state controller: decoded RX primitives,
// port states and helpers that classify states for the statistics counters.
package fc;

    typedef enum logic [2:0] {
        PRIM_NONE = 3'd0,
        PRIM_IDLE = 3'd1,
        PRIM_ARB  = 3'd2,
        PRIM_LR   = 3'd3,
        PRIM_LRR  = 3'd4,
        PRIM_NOS  = 3'd5,
        PRIM_OLS  = 3'd6
    } prim_t;

    typedef enum logic [3:0] {
        STATE_AC  = 4'd0,
        STATE_LR1 = 4'd1,
        STATE_LR2 = 4'd2,
        STATE_LR3 = 4'd3,
        STATE_LF1 = 4'd4,
        STATE_LF2 = 4'd5,
        STATE_OL1 = 4'd6,
        STATE_OL2 = 4'd7,
        STATE_OL3 = 4'd8
    } state_t;

    function automatic logic is_link_fail(state_t s);
        return (s == STATE_LF1) || (s == STATE_LF2);
    endfunction

    function automatic logic is_link_reset(state_t s);
        return (s == STATE_LR1) || (s == STATE_LR2);
    endfunction

endpackage

// File: rtl/fc_port_state_ctrl_if.sv
// Lane-side bundle between the RX decoder/host CSRs and the port state controller.
// Statistics signals exist only when FC_PORT_STATE_STATS_EN is defined.
interface fc_port_state_ctrl_if;
    import fc::*;

    prim_t  rx_prim;
    logic   rx_valid;
    logic   rx_sync;
    logic   req_link_reset;
    logic   req_offline;
    state_t state;
    logic   active;
    logic   state_change;
`ifdef FC_PORT_STATE_STATS_EN
    logic        stat_clear;
    logic [15:0] stat_link_fail;
    logic [15:0] stat_link_reset;

    modport master (
        output rx_prim, rx_valid, rx_sync, req_link_reset, req_offline, stat_clear,
        input  state, active, state_change, stat_link_fail, stat_link_reset
    );
    modport slave (
        input  rx_prim, rx_valid, rx_sync, req_link_reset, req_offline, stat_clear,
        output state, active, state_change, stat_link_fail, stat_link_reset
    );
`else
    modport master (
        output rx_prim, rx_valid, rx_sync, req_link_reset, req_offline,
        input  state, active, state_change
    );
    modport slave (
        input  rx_prim, rx_valid, rx_sync, req_link_reset, req_offline,
        output state, active, state_change
    );
`endif

endinterface

// File: rtl/fc_prim_seq_detect.sv
// Recognises SEQ_LEN consecutive identical valid primitives; the recognised primitive
// is presented from registered state and held for as long as the run continues.
module fc_prim_seq_detect
    import fc::*;
#(
    parameter int SEQ_LEN = 3
) (
    input  logic  clk,
    input  logic  reset_n,
    input  prim_t rx_prim,
    input  logic  rx_valid,
    input  logic  clear,
    output prim_t seq
);

    localparam int CW = $clog2(SEQ_LEN + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    prim_t         prim_q, prim_d;

    always_comb begin
        cnt_d  = cnt_q;
        prim_d = prim_q;
        if (clear) begin
            cnt_d  = '0;
            prim_d = PRIM_NONE;
        end else if (rx_valid && (rx_prim != PRIM_NONE)) begin
            if ((rx_prim == prim_q) && (cnt_q != '0)) begin
                if (cnt_q != CW'(SEQ_LEN)) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else begin
                prim_d = rx_prim;
                cnt_d  = CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            prim_q <= PRIM_NONE;
        end else begin
            cnt_q  <= cnt_d;
            prim_q <= prim_d;
        end
    end

    assign seq = (cnt_q == CW'(SEQ_LEN)) ? prim_q : PRIM_NONE;

endmodule

// File: rtl/fc_port_state_ctrl.sv
// Fibre Channel port state machine for one lane (active/link-recovery/failure/offline).
// Optional saturating entry counters are built when FC_PORT_STATE_STATS_EN is defined.
module fc_port_state_ctrl
    import fc::*;
#(
    parameter int RTTOV_CYCLES  = 10_000_000,
    parameter int LOSTOV_CYCLES = 10_000,
    parameter int SEQ_LEN       = 3
) (
    input logic                 clk,
    input logic                 reset_n,
    fc_port_state_ctrl_if.slave bus
);

    localparam int TW = $clog2(RTTOV_CYCLES + 1);
    localparam int LW = $clog2(LOSTOV_CYCLES + 1);

    state_t        state_q, state_d;
    logic          active_q, active_d;
    logic          chg_q, chg_d;
    logic [TW-1:0] tmr_q;
    logic [LW-1:0] los_q;
    prim_t         seq;
    logic          los;
    logic          tmo;

    fc_prim_seq_detect #(
        .SEQ_LEN (SEQ_LEN)
    ) u_seq (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx_prim  (bus.rx_prim),
        .rx_valid (bus.rx_valid),
        .clear    (!bus.rx_sync),
        .seq      (seq)
    );

    always_ff @(posedge clk) begin
        if (!reset_n || bus.rx_sync) begin
            los_q <= '0;
        end else if (los_q != LW'(LOSTOV_CYCLES)) begin
            los_q <= los_q + LW'(1);
        end
    end

    // Pending timer runs in every state; only the pending states act on it.
    always_ff @(posedge clk) begin
        if (!reset_n || (state_d != state_q)) begin
            tmr_q <= '0;
        end else if (tmr_q != TW'(RTTOV_CYCLES)) begin
            tmr_q <= tmr_q + TW'(1);
        end
    end

    assign los = (los_q == LW'(LOSTOV_CYCLES));
    assign tmo = (tmr_q == TW'(RTTOV_CYCLES));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= STATE_OL1;
            active_q <= 1'b0;
            chg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            chg_q    <= chg_d;
        end
    end

    // A recognised sequence with no action in the current state falls through to
    // host requests and then to the timeout.
    always_comb begin
        state_d = state_q;
        if (los && (state_q != STATE_LF1)) begin
            state_d = STATE_LF1;
        end else begin
            case (state_q)
                STATE_AC: begin
                    if (seq == PRIM_LR)          state_d = STATE_LR2;
                    else if (seq == PRIM_LRR)    state_d = STATE_LR3;
                    else if (seq == PRIM_NOS)    state_d = STATE_LF2;
                    else if (seq == PRIM_OLS)    state_d = STATE_OL2;
                    else if (bus.req_offline)    state_d = STATE_OL1;
                    else if (bus.req_link_reset) state_d = STATE_LR1;
                end
                STATE_LR1: begin
                    if (seq == PRIM_LRR)         state_d = STATE_LR3;
                    else if (seq == PRIM_LR)     state_d = STATE_LR2;
                    else if (seq == PRIM_NOS)    state_d = STATE_LF2;
                    else if (seq == PRIM_OLS)    state_d = STATE_OL2;
                    else if (tmo)                state_d = STATE_LF1;
                end
                STATE_LR2: begin
                    if ((seq == PRIM_IDLE) || (seq == PRIM_ARB)) state_d = STATE_AC;
                    else if (seq == PRIM_LRR)    state_d = STATE_LR3;
                    else if (seq == PRIM_NOS)    state_d = STATE_LF2;
                    else if (seq == PRIM_OLS)    state_d = STATE_OL2;
                    else if (seq == PRIM_LR)     state_d = STATE_LR2;
                    else if (tmo)                state_d = STATE_LF1;
                end
                STATE_LR3: begin
                    if ((seq == PRIM_IDLE) || (seq == PRIM_ARB)) state_d = STATE_AC;
                    else if (seq == PRIM_LR)     state_d = STATE_LR2;
                    else if (seq == PRIM_NOS)    state_d = STATE_LF2;
                    else if (seq == PRIM_OLS)    state_d = STATE_OL2;
                    else if (tmo)                state_d = STATE_LF1;
                end
                STATE_LF1: begin
                    if (bus.rx_sync) begin
                        if (seq == PRIM_NOS)      state_d = STATE_LF2;
                        else if (seq == PRIM_OLS) state_d = STATE_OL2;
                        else if (seq == PRIM_LR)  state_d = STATE_LR2;
                    end
                end
                STATE_LF2: begin
                    if (seq == PRIM_OLS)         state_d = STATE_OL2;
                    else if (seq == PRIM_LR)     state_d = STATE_LR2;
                    else if (bus.req_offline)    state_d = STATE_OL1;
                end
                STATE_OL1: begin
                    if (seq == PRIM_OLS)         state_d = STATE_OL2;
                    else if (seq == PRIM_LR)     state_d = STATE_LR2;
                    else if (seq == PRIM_NOS)    state_d = STATE_OL3;
                end
                STATE_OL2: begin
                    if (seq == PRIM_LRR)         state_d = STATE_LR3;
                    else if (seq == PRIM_LR)     state_d = STATE_LR2;
                    else if (seq == PRIM_NOS)    state_d = STATE_LF2;
                    else if (tmo)                state_d = STATE_LF1;
                end
                STATE_OL3: begin
                    if (seq == PRIM_OLS)         state_d = STATE_OL2;
                    else if (seq == PRIM_LR)     state_d = STATE_LR2;
                end
                default: state_d = STATE_LF1;
            endcase
        end
    end

    always_comb begin
        active_d = (state_d == STATE_AC);
        chg_d    = (state_d != state_q);
    end

    assign bus.state        = state_q;
    assign bus.active       = active_q;
    assign bus.state_change = chg_q;

`ifdef FC_PORT_STATE_STATS_EN
    logic [15:0] stat_fail_q;
    logic [15:0] stat_rst_q;

    always_ff @(posedge clk) begin
        if (!reset_n || bus.stat_clear) begin
            stat_fail_q <= '0;
            stat_rst_q  <= '0;
        end else if (chg_d) begin
            if (is_link_fail(state_d) && (stat_fail_q != 16'hFFFF)) begin
                stat_fail_q <= stat_fail_q + 16'd1;
            end
            if (is_link_reset(state_d) && (stat_rst_q != 16'hFFFF)) begin
                stat_rst_q <= stat_rst_q + 16'd1;
            end
        end
    end

    assign bus.stat_link_fail  = stat_fail_q;
    assign bus.stat_link_reset = stat_rst_q;
`endif

endmodule
